// File: rtl/dsp_mac_sequencer_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | dsp_mac_sequencer_if                                                   |
// | Operand-pair stream and dot-product result handshakes.                 |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
interface dsp_mac_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] in_a;
    logic [17:0] in_b;
    logic        in_last;
    logic        res_valid;
    logic        res_ready;
    logic [47:0] res_data;
    logic        res_ovf;

    modport master (
        output in_valid, in_a, in_b, in_last, res_ready,
        input  in_ready, res_valid, res_data, res_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, res_ready,
        output in_ready, res_valid, res_data, res_ovf
    );
endinterface
`default_nettype wire

// File: rtl/dsp_mac_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | dsp_mac_sequencer                                                      |
// | Drives a DSP slice in MAC mode, accumulating operand-pair dot products.|
// | Optional macro DSP_SEQ_BIAS_EN seeds each vector with a C-port bias.   |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module dsp_mac_sequencer #(
    parameter int OP_LAG  = 1,
    parameter int RES_LAT = 3
) (
    input  wire logic          clk,
    input  wire logic          rst,
    dsp_mac_sequencer_if.slave bus,
    output logic [17:0]        dsp_A,
    output logic [17:0]        dsp_B,
    output logic [7:0]         dsp_opmode,
    input  wire logic [47:0]   dsp_P,
    input  wire logic          dsp_carryout
`ifdef DSP_SEQ_BIAS_EN
    ,
    input  wire logic [47:0]   bias,
    output logic [47:0]        dsp_C
`endif
);

    localparam int CW = $clog2(RES_LAT + 1);

`ifdef DSP_SEQ_BIAS_EN
    localparam logic [7:0] c_op_first = 8'b0000_1101;
`else
    localparam logic [7:0] c_op_first = 8'b0000_0001;
`endif
    localparam logic [7:0] c_op_acc   = 8'b0000_1001;
    localparam logic [7:0] c_op_hold  = 8'b0000_1000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [17:0]            a_q, b_q;
    logic [OP_LAG:0][7:0]   op_dly_q;
    logic [RES_LAT:0]       tag_q;
    logic                   res_valid_q, res_valid_d;
    logic [47:0]            res_data_q, res_data_d;
    logic                   res_ovf_q, res_ovf_d;
    logic                   ovf_acc_q, ovf_acc_d;

    logic                   w_ready;
    logic                   w_accept;
    logic                   w_first;
    logic [7:0]             w_slot;
    logic                   w_ovf_hit;

    // Carry is meaningful only when P holds a product slot of this vector.
    assign w_ovf_hit = tag_q[RES_LAT] & dsp_carryout;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        w_ready     = 1'b0;
        w_accept    = 1'b0;
        w_first     = 1'b0;
        w_slot      = c_op_hold;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_ovf_d   = res_ovf_q;
        case (state_q)
            S_IDLE: begin
                w_ready = !res_valid_q;
                if (bus.in_valid && w_ready) begin
                    w_accept = 1'b1;
                    w_first  = 1'b1;
                    w_slot   = c_op_first;
                    state_d  = bus.in_last ? S_DRAIN : S_ACCUM;
                    cnt_d    = CW'(RES_LAT);
                end
            end
            S_ACCUM: begin
                w_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept = 1'b1;
                    w_slot   = c_op_acc;
                    if (bus.in_last) begin
                        state_d = S_DRAIN;
                        cnt_d   = CW'(RES_LAT);
                    end
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) begin
                    res_valid_d = 1'b1;
                    res_data_d  = dsp_P;
                    res_ovf_d   = ovf_acc_q | w_ovf_hit;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (res_valid_q && bus.res_ready) begin
            res_valid_d = 1'b0;
        end
        ovf_acc_d = w_first ? 1'b0 : (ovf_acc_q | w_ovf_hit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_dly_q    <= '0;
            tag_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_ovf_q   <= 1'b0;
            ovf_acc_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            if (w_accept) begin
                a_q <= bus.in_a;
                b_q <= bus.in_b;
            end
            op_dly_q    <= {op_dly_q[OP_LAG-1:0], w_slot};
            tag_q       <= {tag_q[RES_LAT-1:0], w_accept};
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_ovf_q   <= res_ovf_d;
            ovf_acc_q   <= ovf_acc_d;
        end
    end

`ifdef DSP_SEQ_BIAS_EN
    logic [OP_LAG:0][47:0] c_dly_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_dly_q <= '0;
        end else begin
            c_dly_q <= {c_dly_q[OP_LAG-1:0], (w_first ? bias : c_dly_q[0])};
        end
    end

    assign dsp_C = c_dly_q[OP_LAG];
`endif

    assign bus.in_ready  = w_ready && !rst;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_ovf   = res_ovf_q;
    assign dsp_A         = a_q;
    assign dsp_B         = b_q;
    assign dsp_opmode    = op_dly_q[OP_LAG];

endmodule
`default_nettype wire
